// File: rtl/hazard_ctrl_pkg.sv
// Shared rv32i types for the hazard controller: register numbers, opcodes,
// the EX control word and the hazard FSM state.
package hazard_ctrl_pkg;

   localparam int unsigned REG_W    = 5;
   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned CNT_W    = 32;

   typedef logic [REG_W-1:0] rv32i_reg;

   typedef enum logic [OPCODE_W-1:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef struct packed {
      rv32i_opcode opcode;
      logic        load_regfile;
   } rv32i_control_word;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LU_BUBBLE = 2'd1,
      FLUSH     = 2'd2
   } hazard_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. master = pipeline/memory side,
// slave = hazard_ctrl.
interface hazard_ctrl_if;
   import hazard_ctrl_pkg::*;

   rv32i_reg          ID_rs1_num;
   rv32i_reg          ID_rs2_num;
   logic              ID_uses_rs1;
   logic              ID_uses_rs2;
   rv32i_reg          EX_rd_num;
   rv32i_control_word EX_ctrlword;
   logic              EX_br_taken;
   logic              imem_req;
   logic              imem_resp;
   logic              dmem_req;
   logic              dmem_resp;

   logic              pc_load;
   logic              IF_ID_load;
   logic              ID_EX_load;
   logic              EX_MEM_load;
   logic              MEM_WB_load;
   logic              IF_ID_flush;
   logic              ID_EX_flush;
   logic              pc_sel_target;
   logic [CNT_W-1:0]  cnt_lu;
   logic [CNT_W-1:0]  cnt_mem;
   logic [CNT_W-1:0]  cnt_flush;

   modport master (
      output ID_rs1_num, ID_rs2_num, ID_uses_rs1, ID_uses_rs2,
      output EX_rd_num, EX_ctrlword, EX_br_taken,
      output imem_req, imem_resp, dmem_req, dmem_resp,
      input  pc_load, IF_ID_load, ID_EX_load, EX_MEM_load, MEM_WB_load,
      input  IF_ID_flush, ID_EX_flush, pc_sel_target,
      input  cnt_lu, cnt_mem, cnt_flush
   );

   modport slave (
      input  ID_rs1_num, ID_rs2_num, ID_uses_rs1, ID_uses_rs2,
      input  EX_rd_num, EX_ctrlword, EX_br_taken,
      input  imem_req, imem_resp, dmem_req, dmem_resp,
      output pc_load, IF_ID_load, ID_EX_load, EX_MEM_load, MEM_WB_load,
      output IF_ID_flush, ID_EX_flush, pc_sel_target,
      output cnt_lu, cnt_mem, cnt_flush
   );

endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// Saturating hazard performance counters; only built when HAZARD_PERF_CNT_EN
// is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt
   import hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lu_evt,
   input  logic             mem_evt,
   input  logic             flush_evt,
   output logic [CNT_W-1:0] cnt_lu,
   output logic [CNT_W-1:0] cnt_mem,
   output logic [CNT_W-1:0] cnt_flush
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_lu    <= '0;
         cnt_mem   <= '0;
         cnt_flush <= '0;
      end else begin
         if (lu_evt)    cnt_lu    <= sat_inc(cnt_lu);
         if (mem_evt)   cnt_mem   <= sat_inc(cnt_mem);
         if (flush_evt) cnt_flush <= sat_inc(cnt_flush);
      end
   end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, imem/dmem freeze, branch flush.
// Optional performance counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave hz
);
   import hazard_ctrl_pkg::*;

   hazard_state_t state, state_nxt;
   logic          discard_fetch, discard_nxt;

   logic data_wait, fetch_wait, load_use, lu_take, branch;
   logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
   logic if_id_flush, id_ex_flush, pc_sel_target;

   assign data_wait  = hz.dmem_req && !hz.dmem_resp;
   assign fetch_wait = hz.imem_req && !hz.imem_resp;
   assign load_use   = (hz.EX_ctrlword.opcode == op_load) && hz.EX_ctrlword.load_regfile
                       && (hz.EX_rd_num != '0)
                       && ((hz.ID_uses_rs1 && (hz.ID_rs1_num == hz.EX_rd_num)) ||
                           (hz.ID_uses_rs2 && (hz.ID_rs2_num == hz.EX_rd_num)));
   // One bubble per hazard: the check is skipped while the bubble is in flight.
   assign lu_take    = (state == RUN) && load_use;
   assign branch     = hz.EX_br_taken && (state != FLUSH);

   // Next state, discard tracking and Mealy enables by priority.
   always_comb begin
      pc_load       = 1'b1;
      if_id_load    = 1'b1;
      id_ex_load    = 1'b1;
      ex_mem_load   = 1'b1;
      mem_wb_load   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      pc_sel_target = 1'b0;
      state_nxt     = RUN;
      discard_nxt   = discard_fetch && !hz.imem_resp;

      if (!rst_n) begin
         pc_load     = 1'b0;
         if_id_load  = 1'b0;
         id_ex_load  = 1'b0;
         ex_mem_load = 1'b0;
         mem_wb_load = 1'b0;
      end else if (data_wait) begin
         pc_load     = 1'b0;
         if_id_load  = 1'b0;
         id_ex_load  = 1'b0;
         ex_mem_load = 1'b0;
         mem_wb_load = 1'b0;
         state_nxt   = state;
         discard_nxt = discard_fetch;
      end else if (branch) begin
         pc_sel_target = 1'b1;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         state_nxt     = FLUSH;
         discard_nxt   = discard_nxt || fetch_wait;
      end else begin
         if (lu_take) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_flush = 1'b1;
            state_nxt   = LU_BUBBLE;
         end else if (fetch_wait) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_flush = 1'b1;
         end
         // PC already holds the target; drop the wrong-path fetch when it lands.
         if (discard_fetch) begin
            pc_load = 1'b0;
            if (hz.imem_resp) if_id_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RUN;
         discard_fetch <= 1'b0;
      end else if (!data_wait) begin
         state         <= state_nxt;
         discard_fetch <= discard_nxt;
      end
   end

   assign hz.pc_load       = pc_load;
   assign hz.IF_ID_load    = if_id_load;
   assign hz.ID_EX_load    = id_ex_load;
   assign hz.EX_MEM_load   = ex_mem_load;
   assign hz.MEM_WB_load   = mem_wb_load;
   assign hz.IF_ID_flush   = if_id_flush;
   assign hz.ID_EX_flush   = id_ex_flush;
   assign hz.pc_sel_target = pc_sel_target;

`ifdef HAZARD_PERF_CNT_EN
   logic             lu_evt, mem_evt, flush_evt;
   logic [CNT_W-1:0] cnt_lu, cnt_mem, cnt_flush;

   assign lu_evt    = !data_wait && !branch && lu_take;
   assign mem_evt   = data_wait;
   assign flush_evt = !data_wait && branch;

   hazard_perf_cnt u_perf_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .lu_evt    (lu_evt),
      .mem_evt   (mem_evt),
      .flush_evt (flush_evt),
      .cnt_lu    (cnt_lu),
      .cnt_mem   (cnt_mem),
      .cnt_flush (cnt_flush)
   );

   assign hz.cnt_lu    = cnt_lu;
   assign hz.cnt_mem   = cnt_mem;
   assign hz.cnt_flush = cnt_flush;
`else
   assign hz.cnt_lu    = '0;
   assign hz.cnt_mem   = '0;
   assign hz.cnt_flush = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   // {pc_load, IF_ID_load, ID_EX_load, EX_MEM_load, MEM_WB_load, IF_ID_flush, ID_EX_flush, pc_sel_target}
   localparam logic [7:0] E_NORM  = 8'b11111_000;
   localparam logic [7:0] E_ZERO  = 8'b00000_000;
   localparam logic [7:0] E_STALL = 8'b00111_010;
   localparam logic [7:0] E_BR    = 8'b11111_111;
   localparam logic [7:0] E_DROP  = 8'b01111_100;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [7:0] obs;

   hazard_ctrl_if hif ();

   hazard_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hif)
   );

   assign obs = {hif.pc_load, hif.IF_ID_load, hif.ID_EX_load, hif.EX_MEM_load,
                 hif.MEM_WB_load, hif.IF_ID_flush, hif.ID_EX_flush, hif.pc_sel_target};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_cnt(input int unsigned n);
`ifdef HAZARD_PERF_CNT_EN
      return 32'(n);
`else
      return 32'(0 * n);
`endif
   endfunction

   task automatic drive_idle();
      hif.ID_rs1_num  = 5'd0;
      hif.ID_rs2_num  = 5'd0;
      hif.ID_uses_rs1 = 1'b0;
      hif.ID_uses_rs2 = 1'b0;
      hif.EX_rd_num   = 5'd0;
      hif.EX_ctrlword = '{opcode: op_imm, load_regfile: 1'b0};
      hif.EX_br_taken = 1'b0;
      hif.imem_req    = 1'b1;
      hif.imem_resp   = 1'b1;
      hif.dmem_req    = 1'b0;
      hif.dmem_resp   = 1'b0;
   endtask

   // lw x5 in EX
   task automatic drive_lw_x5();
      hif.EX_rd_num   = 5'd5;
      hif.EX_ctrlword = '{opcode: op_load, load_regfile: 1'b1};
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if (obs !== E_ZERO) begin n_err++; $display("FAIL reset_outs: got %b want %b", obs, E_ZERO); end
      n_cmp++;
      if (hif.cnt_lu !== 32'd0 || hif.cnt_mem !== 32'd0 || hif.cnt_flush !== 32'd0) begin
         n_err++;
         $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", hif.cnt_lu, hif.cnt_mem, hif.cnt_flush);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL reset_release: got %b want %b", obs, E_NORM); end
   endtask

   task automatic test_load_use();
      // add x6,x5,x1 behind lw x5 (rs1 match)
      @(negedge clk);
      drive_idle(); drive_lw_x5();
      hif.ID_rs1_num = 5'd5; hif.ID_uses_rs1 = 1'b1;
      hif.ID_rs2_num = 5'd1; hif.ID_uses_rs2 = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_STALL) begin n_err++; $display("FAIL lu_rs1: got %b want %b", obs, E_STALL); end
      // Same inputs in LU_BUBBLE must not stall again
      @(negedge clk); #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL lu_once: got %b want %b", obs, E_NORM); end
      // rs2 match
      @(negedge clk);
      drive_idle(); drive_lw_x5();
      hif.ID_rs1_num = 5'd2; hif.ID_uses_rs1 = 1'b1;
      hif.ID_rs2_num = 5'd5; hif.ID_uses_rs2 = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_STALL) begin n_err++; $display("FAIL lu_rs2: got %b want %b", obs, E_STALL); end
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL lu_after: got %b want %b", obs, E_NORM); end
      @(negedge clk); #1;
      n_cmp++;
      if (hif.cnt_lu !== exp_cnt(2)) begin n_err++; $display("FAIL cnt_lu: got %0d want %0d", hif.cnt_lu, exp_cnt(2)); end
   endtask

   task automatic test_no_hazard();
      // op_imm with rs2 field = x5 but rs2 unused
      @(negedge clk);
      drive_idle(); drive_lw_x5();
      hif.ID_rs1_num = 5'd2; hif.ID_uses_rs1 = 1'b1;
      hif.ID_rs2_num = 5'd5; hif.ID_uses_rs2 = 1'b0;
      #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL op_imm_rs2: got %b want %b", obs, E_NORM); end
      // lw x0 followed by consumer of x0
      @(negedge clk);
      drive_idle();
      hif.EX_rd_num   = 5'd0;
      hif.EX_ctrlword = '{opcode: op_load, load_regfile: 1'b1};
      hif.ID_rs1_num = 5'd0; hif.ID_uses_rs1 = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL load_x0: got %b want %b", obs, E_NORM); end
      // ALU op writing x5 is covered by forwarding
      @(negedge clk);
      drive_idle();
      hif.EX_rd_num   = 5'd5;
      hif.EX_ctrlword = '{opcode: op_reg, load_regfile: 1'b1};
      hif.ID_rs1_num = 5'd5; hif.ID_uses_rs1 = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL alu_rd: got %b want %b", obs, E_NORM); end
   endtask

   task automatic test_dmem_branch();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_idle();
         hif.dmem_req = 1'b1; hif.dmem_resp = 1'b0; hif.EX_br_taken = 1'b1;
         #1;
         n_cmp++;
         if (obs !== E_ZERO) begin n_err++; $display("FAIL dwait_%0d: got %b want %b", i, obs, E_ZERO); end
      end
      @(negedge clk);
      hif.dmem_resp = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_BR) begin n_err++; $display("FAIL dwait_br: got %b want %b", obs, E_BR); end
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL flush_state: got %b want %b", obs, E_NORM); end
      @(negedge clk); #1;
      n_cmp++;
      if (hif.cnt_mem !== exp_cnt(3)) begin n_err++; $display("FAIL cnt_mem: got %0d want %0d", hif.cnt_mem, exp_cnt(3)); end
      n_cmp++;
      if (hif.cnt_flush !== exp_cnt(1)) begin n_err++; $display("FAIL cnt_flush1: got %0d want %0d", hif.cnt_flush, exp_cnt(1)); end
   endtask

   task automatic test_branch_lu();
      @(negedge clk);
      drive_idle(); drive_lw_x5();
      hif.ID_rs1_num = 5'd5; hif.ID_uses_rs1 = 1'b1;
      hif.EX_br_taken = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_BR) begin n_err++; $display("FAIL br_vs_lu: got %b want %b", obs, E_BR); end
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL br_vs_lu_next: got %b want %b", obs, E_NORM); end
      @(negedge clk); #1;
      n_cmp++;
      if (hif.cnt_lu !== exp_cnt(2) || hif.cnt_flush !== exp_cnt(2)) begin
         n_err++;
         $display("FAIL cnt_br_lu: got lu=%0d fl=%0d want lu=%0d fl=%0d",
                  hif.cnt_lu, hif.cnt_flush, exp_cnt(2), exp_cnt(2));
      end
   endtask

   task automatic test_branch_fetch();
      // Plain drain: resp two cycles after the branch
      @(negedge clk);
      drive_idle();
      hif.imem_resp = 1'b0; hif.EX_br_taken = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_BR) begin n_err++; $display("FAIL bf_br: got %b want %b", obs, E_BR); end
      @(negedge clk);
      hif.EX_br_taken = 1'b0;
      #1;
      n_cmp++;
      if (obs !== E_STALL) begin n_err++; $display("FAIL bf_wait: got %b want %b", obs, E_STALL); end
      @(negedge clk);
      hif.imem_resp = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_DROP) begin n_err++; $display("FAIL bf_drop: got %b want %b", obs, E_DROP); end
      @(negedge clk); #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL bf_target: got %b want %b", obs, E_NORM); end
      // Wrong-path resp lands under a data wait: discard must hold
      @(negedge clk);
      hif.imem_resp = 1'b0; hif.EX_br_taken = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_BR) begin n_err++; $display("FAIL bfd_br: got %b want %b", obs, E_BR); end
      @(negedge clk);
      hif.EX_br_taken = 1'b0;
      #1;
      n_cmp++;
      if (obs !== E_STALL) begin n_err++; $display("FAIL bfd_wait: got %b want %b", obs, E_STALL); end
      @(negedge clk);
      hif.imem_resp = 1'b1; hif.dmem_req = 1'b1; hif.dmem_resp = 1'b0;
      #1;
      n_cmp++;
      if (obs !== E_ZERO) begin n_err++; $display("FAIL bfd_dwait: got %b want %b", obs, E_ZERO); end
      @(negedge clk);
      hif.dmem_resp = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_DROP) begin n_err++; $display("FAIL bfd_drop: got %b want %b", obs, E_DROP); end
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL bfd_target: got %b want %b", obs, E_NORM); end
      @(negedge clk); #1;
      n_cmp++;
      if (hif.cnt_flush !== exp_cnt(4) || hif.cnt_mem !== exp_cnt(4)) begin
         n_err++;
         $display("FAIL cnt_bf: got fl=%0d mem=%0d want fl=%0d mem=%0d",
                  hif.cnt_flush, hif.cnt_mem, exp_cnt(4), exp_cnt(4));
      end
   endtask

   task automatic test_reset_mid_stall();
      // Branch with outstanding fetch -> FLUSH, discard_fetch=1
      @(negedge clk);
      drive_idle();
      hif.imem_resp = 1'b0; hif.EX_br_taken = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_BR) begin n_err++; $display("FAIL rms_br: got %b want %b", obs, E_BR); end
      @(negedge clk);
      hif.EX_br_taken = 1'b0;
      #1;
      n_cmp++;
      if (obs !== E_STALL) begin n_err++; $display("FAIL rms_flush: got %b want %b", obs, E_STALL); end
      // RUN with discard pending: load-use -> LU_BUBBLE
      @(negedge clk);
      drive_lw_x5();
      hif.ID_rs1_num = 5'd5; hif.ID_uses_rs1 = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_STALL) begin n_err++; $display("FAIL rms_lu: got %b want %b", obs, E_STALL); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== E_ZERO) begin n_err++; $display("FAIL rms_rst: got %b want %b", obs, E_ZERO); end
      n_cmp++;
      if (hif.cnt_lu !== 32'd0 || hif.cnt_mem !== 32'd0 || hif.cnt_flush !== 32'd0) begin
         n_err++;
         $display("FAIL rms_cnt_clr: got %0d/%0d/%0d want 0/0/0", hif.cnt_lu, hif.cnt_mem, hif.cnt_flush);
      end
      // After release: RUN (load-use stalls) and the resp is not discarded
      @(negedge clk);
      rst_n = 1'b1;
      hif.imem_req = 1'b1; hif.imem_resp = 1'b1;
      #1;
      n_cmp++;
      if (obs !== E_STALL) begin n_err++; $display("FAIL rms_post: got %b want %b", obs, E_STALL); end
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++;
      if (obs !== E_NORM) begin n_err++; $display("FAIL rms_post2: got %b want %b", obs, E_NORM); end
      n_cmp++;
      if (hif.cnt_lu !== exp_cnt(1)) begin n_err++; $display("FAIL rms_cnt_lu: got %0d want %0d", hif.cnt_lu, exp_cnt(1)); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive_idle();
      test_reset();
      test_load_use();
      test_no_hazard();
      test_dmem_branch();
      test_branch_lu();
      test_branch_fetch();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
